core_test_sequencer: RTL and testbench
======================================

CORE_TEST_SEQUENCER -- requirements
Module: core_test_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/register word width.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning word-address width of preload target memories.
REQ-003 SHALL have parameter NUM_CHECKS, default 3, range 1..32, meaning number of register-result checks.
REQ-004 SHALL have parameter RUN_CYCLES, default 40, range 1..65535, meaning maximum core run length in clk cycles.
REQ-005 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  begin sequence; core_halt  in  1  core finished early.
REQ-007 SHALL have ports: load_valid  in  1; load_ready  out  1; load_sel  in  2  target (0 imem, 1 dmem, 2 regfile, 3 reserved); load_addr  in  ADDR_W; load_data  in  XLEN; load_last  in  1  final preload word.
REQ-008 SHALL have ports: wr_en  out  1; wr_sel  out  2; wr_addr  out  ADDR_W; wr_data  out  XLEN  registered preload write to core memories.
REQ-009 SHALL have port core_rst_n  out  1  active-low reset driven to the core.
REQ-010 SHALL have ports: chk_idx  out  5  check-table index; chk_reg  in  5  register to check; chk_exp  in  XLEN  expected value (combinational table).
REQ-011 SHALL have ports: rf_raddr  out  5; rf_rdata  in  XLEN  combinational register-file read.
REQ-012 SHALL have ports: busy  out  1; done  out  1; pass  out  1; err_count  out  6; fail_idx  out  5  index of first failing check.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, CHECK, DONE.
REQ-014 IDLE: start=1 -> LOAD next cycle; busy=0; done/pass keep previous result until start.
REQ-015 On start, done, pass, err_count, fail_idx SHALL clear in the same edge that enters LOAD.
REQ-016 LOAD: load_ready=1; each cycle with load_valid&load_ready SHALL produce wr_en=1 with wr_sel/wr_addr/wr_data of that word exactly one cycle later.
REQ-017 Handshake with load_sel=3 SHALL be accepted but produce no write (wr_en stays 0).
REQ-018 Handshake with load_last=1 SHALL write that word and move to RUN next cycle; load_ready=0 outside LOAD.
REQ-019 core_rst_n SHALL be 0 in IDLE, LOAD, CHECK, DONE and 1 only in RUN.
REQ-020 RUN: 16-bit cycle counter starts at 0 on entry, increments each cycle; exit to CHECK when counter reaches RUN_CYCLES-1 or core_halt=1, whichever first.
REQ-021 core_halt outside RUN SHALL be ignored.
REQ-022 CHECK: one check per cycle, idx 0..NUM_CHECKS-1; chk_idx=idx, rf_raddr=chk_reg; compare rf_rdata to chk_exp same cycle.
REQ-023 On mismatch, err_count SHALL increment, saturating at 63; fail_idx SHALL capture idx of first mismatch only.
REQ-024 chk_reg=0 SHALL compare against constant 0, not rf_rdata.
REQ-025 After idx NUM_CHECKS-1, SHALL enter DONE; done=1, pass=(err_count==0) registered on entry.
REQ-026 DONE -> IDLE next cycle; busy=1 in LOAD, RUN, CHECK.
REQ-027 start while busy SHALL be ignored; start and load_valid arriving together in IDLE: load_valid not accepted that cycle.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, core_rst_n=0, load_ready=0, wr_en=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0, chk_idx=0, rf_raddr=0, counters 0.
REQ-029 Reset asserted mid-LOAD or mid-RUN SHALL abandon the sequence; no pending wr_en issued after reset deassertion.

Verification
REQ-030 Load 3 imem words (addr 0..2, last on 2) -> wr_en pulses one cycle after each handshake, addr 0,1,2, then core_rst_n=1 for 40 cycles.
REQ-031 Checks {x23=0x8, x24=0xA, x7=0x3A} with matching rf_rdata -> done=1, pass=1, err_count=0.
REQ-032 Same, x24 reads 0xB and x7 reads 0 -> pass=0, err_count=2, fail_idx=1.
REQ-033 core_halt=1 at RUN cycle 5 -> CHECK next cycle, core_rst_n=0, total RUN length 6 cycles.
REQ-034 load_sel=3 word and chk_reg=0 with chk_exp=0, rf_rdata=0xFFFFFFFF -> no write for that word, check passes.
REQ-035 rst=0 during RUN cycle 10 -> immediate IDLE, core_rst_n=0, busy=0; new start runs full sequence normally.

Source files
------------

// File: rtl/core_test_sequencer.sv
// Test sequencer for a CPU core: preloads core memories, releases the core for a bounded
// run, then compares a table of register results against the core's register file.
module core_test_sequencer #(
   parameter int XLEN       = 32,
   parameter int ADDR_W     = 10,
   parameter int NUM_CHECKS = 3,
   parameter int RUN_CYCLES = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              core_halt,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [1:0]        load_sel,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [XLEN-1:0]   load_data,
   input  logic              load_last,
   output logic              wr_en,
   output logic [1:0]        wr_sel,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [XLEN-1:0]   wr_data,
   output logic              core_rst_n,
   output logic [4:0]        chk_idx,
   input  logic [4:0]        chk_reg,
   input  logic [XLEN-1:0]   chk_exp,
   output logic [4:0]        rf_raddr,
   input  logic [XLEN-1:0]   rf_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [5:0]        err_count,
   output logic [4:0]        fail_idx
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;

   localparam logic [15:0] RUN_LAST = 16'(RUN_CYCLES - 1);
   localparam logic [4:0]  CHK_LAST = 5'(NUM_CHECKS - 1);

   state_t          state;
   logic [15:0]     run_cnt;
   logic [XLEN-1:0] rd_val;
   logic            mismatch;

   // x0 is hard-wired zero, so it is never read from the register file
   assign rd_val   = (chk_reg == 5'd0) ? '0 : rf_rdata;
   assign mismatch = (rd_val != chk_exp);
   assign rf_raddr = (state == CHECK) ? chk_reg : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         run_cnt    <= '0;
         load_ready <= 1'b0;
         wr_en      <= 1'b0;
         wr_sel     <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
         core_rst_n <= 1'b0;
         chk_idx    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_idx   <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= LOAD;
                  load_ready <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_idx   <= '0;
               end
            end
            LOAD: begin
               if (load_valid && load_ready) begin
                  wr_en   <= (load_sel != 2'd3);
                  wr_sel  <= load_sel;
                  wr_addr <= load_addr;
                  wr_data <= load_data;
                  if (load_last) begin
                     state      <= RUN;
                     load_ready <= 1'b0;
                     core_rst_n <= 1'b1;
                     run_cnt    <= '0;
                  end
               end
            end
            RUN: begin
               run_cnt <= run_cnt + 16'd1;
               if (run_cnt == RUN_LAST || core_halt) begin
                  state      <= CHECK;
                  core_rst_n <= 1'b0;
                  run_cnt    <= '0;
                  chk_idx    <= '0;
               end
            end
            CHECK: begin
               if (mismatch) begin
                  if (err_count != 6'h3F) err_count <= err_count + 6'd1;
                  if (err_count == 6'd0)  fail_idx  <= chk_idx;
               end
               if (chk_idx == CHK_LAST) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  pass    <= (err_count == 6'd0) && !mismatch;
                  busy    <= 1'b0;
                  chk_idx <= '0;
               end else begin
                  chk_idx <= chk_idx + 5'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_test_sequencer.sv
// Bench for core_test_sequencer: directed vector table plus randomized full sequences
// checked against an abstract model of load/run/check behaviour.
module tb_core_test_sequencer;

   localparam int XLEN = 32;
   localparam int ADDR_W = 10;
   localparam int NC = 3;
   localparam int RC = 40;

   logic              clk = 1'b0;
   logic              rst, start, core_halt, load_valid, load_last;
   logic [1:0]        load_sel;
   logic [ADDR_W-1:0] load_addr;
   logic [XLEN-1:0]   load_data;
   logic              load_ready, wr_en, core_rst_n, busy, done, pass;
   logic [1:0]        wr_sel;
   logic [ADDR_W-1:0] wr_addr;
   logic [XLEN-1:0]   wr_data;
   logic [4:0]        chk_idx, chk_reg, rf_raddr, fail_idx;
   logic [XLEN-1:0]   chk_exp, rf_rdata;
   logic [5:0]        err_count;

   logic [4:0]      tbl_reg [32];
   logic [XLEN-1:0] tbl_exp [32];
   logic [XLEN-1:0] rf      [32];

   assign chk_reg  = tbl_reg[chk_idx];
   assign chk_exp  = tbl_exp[chk_idx];
   assign rf_rdata = rf[rf_raddr];

   core_test_sequencer #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_CHECKS(NC), .RUN_CYCLES(RC)) dut (
      .clk(clk), .rst(rst), .start(start), .core_halt(core_halt),
      .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
      .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .core_rst_n(core_rst_n), .chk_idx(chk_idx), .chk_reg(chk_reg), .chk_exp(chk_exp),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_idx(fail_idx)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int                nw;
   logic [1:0]        w_sel  [8];
   logic [ADDR_W-1:0] w_addr [8];
   logic [XLEN-1:0]   w_data [8];

   typedef struct {
      int                    nwords;
      int                    sel3_pos;
      int                    halt_at;
      logic [2:0][4:0]       regs;
      logic [2:0][XLEN-1:0]  exps;
      logic [2:0][XLEN-1:0]  rdv;
      int                    exp_err;
      int                    exp_fail;
      bit                    exp_pass;
      int                    exp_run;
   } vec_t;

   function automatic vec_t mk(input int nwords, input int sel3_pos, input int halt_at,
                               input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                               input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                               input int err, input int fail, input bit ps, input int run);
      vec_t v;
      v.nwords = nwords; v.sel3_pos = sel3_pos; v.halt_at = halt_at;
      v.regs[0] = r0; v.regs[1] = r1; v.regs[2] = r2;
      v.exps[0] = e0; v.exps[1] = e1; v.exps[2] = e2;
      v.rdv[0]  = d0; v.rdv[1]  = d1; v.rdv[2]  = d2;
      v.exp_err = err; v.exp_fail = fail; v.exp_pass = ps; v.exp_run = run;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_word(input int i, input bit rnd);
      load_valid = 1'b1;
      load_sel   = w_sel[i];
      load_addr  = w_addr[i];
      load_data  = w_data[i];
      load_last  = (i == nw - 1);
      core_halt  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   // Runs a full sequence from IDLE; the start cycle also presents word 0, which must not be taken.
   task automatic run_seq(input int halt_at, input int exp_err, input int exp_fail,
                          input bit exp_pass, input int exp_run, input bit rnd);
      int run_len;
      int cyc;
      drive_word(0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_ready", load_ready, 1);
      chk("start_clr_done", done, 0);
      chk("start_clr_err", err_count, 0);
      chk("start_clr_fail", fail_idx, 0);
      chk("start_no_accept", wr_en, 0);
      for (int i = 0; i < nw; i++) begin
         while (rnd && $urandom_range(0, 2) == 0) begin
            load_valid = 1'b0;
            core_halt  = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            tick();
            chk("gap_wr_en", wr_en, 0);
         end
         drive_word(i, rnd);
         start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         chk("wr_en", wr_en, (w_sel[i] != 2'd3));
         if (w_sel[i] != 2'd3) begin
            chk("wr_sel", wr_sel, w_sel[i]);
            chk("wr_addr", wr_addr, w_addr[i]);
            chk("wr_data", wr_data, w_data[i]);
         end
      end
      load_valid = 1'b0; load_last = 1'b0; start = 1'b0; core_halt = 1'b0;
      chk("run_core_rst_n", core_rst_n, 1);
      chk("run_ready_low", load_ready, 0);
      run_len = 1;
      cyc = 0;
      forever begin
         core_halt = (cyc == halt_at);
         start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         core_halt = 1'b0;
         if (core_rst_n !== 1'b1 || run_len > RC + 5) break;
         run_len++;
         cyc++;
      end
      start = 1'b0;
      chk("run_len", run_len, exp_run);
      chk("check_busy", busy, 1);
      for (int i = 0; i < NC; i++) begin
         chk("chk_idx", chk_idx, i);
         chk("rf_raddr", rf_raddr, tbl_reg[i]);
         chk("check_core_rst_n", core_rst_n, 0);
         tick();
      end
      chk("done", done, 1);
      chk("pass", pass, exp_pass);
      chk("err_count", err_count, exp_err);
      chk("fail_idx", fail_idx, exp_fail);
      chk("done_busy", busy, 0);
      tick();
      chk("idle_done_hold", done, 1);
      chk("idle_pass_hold", pass, exp_pass);
      chk("idle_busy", busy, 0);
   endtask

   vec_t vecs [6];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int h, e_err, e_fail, e_run;
      logic [XLEN-1:0] v;

      vecs[0] = mk(3, -1, -1, 5'd23, 5'd24, 5'd7, 32'h8, 32'hA, 32'h3A, 32'h8, 32'hA, 32'h3A, 0, 0, 1, 40);
      vecs[1] = mk(3, -1, -1, 5'd23, 5'd24, 5'd7, 32'h8, 32'hA, 32'h3A, 32'h8, 32'hB, 32'h0, 2, 1, 0, 40);
      vecs[2] = mk(3, -1, 5, 5'd23, 5'd24, 5'd7, 32'h8, 32'hA, 32'h3A, 32'h8, 32'hA, 32'h3A, 0, 0, 1, 6);
      vecs[3] = mk(3, 1, -1, 5'd0, 5'd24, 5'd7, 32'h0, 32'hA, 32'h3A, 32'hFFFFFFFF, 32'hA, 32'h3A, 0, 0, 1, 40);
      vecs[4] = mk(2, -1, 0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h1, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 1, 1, 0, 1);
      vecs[5] = mk(1, 0, 39, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0, 32'h0, 3, 0, 0, 40);

      for (int i = 0; i < 32; i++) begin
         tbl_reg[i] = '0; tbl_exp[i] = '0; rf[i] = '0;
      end
      rst = 1'b0; start = 1'b0; core_halt = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      load_sel = '0; load_addr = '0; load_data = '0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_fail", fail_idx, 0);
      chk("rst_core_rst_n", core_rst_n, 0);
      chk("rst_ready", load_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_chk_idx", chk_idx, 0);
      chk("rst_raddr", rf_raddr, 0);
      rst = 1'b1;
      tick();

      // reset while a write is pending in LOAD
      nw = 2;
      w_sel[0] = 2'd1; w_addr[0] = 10'h15; w_data[0] = 32'hDEAD0001;
      w_sel[1] = 2'd2; w_addr[1] = 10'h16; w_data[1] = 32'hDEAD0002;
      start = 1'b1; tick(); start = 1'b0;
      drive_word(0, 1'b0); tick();
      chk("mid_load_wr_en", wr_en, 1);
      rst = 1'b0; #1;
      chk("load_rst_wr_en", wr_en, 0);
      chk("load_rst_ready", load_ready, 0);
      @(negedge clk) rst = 1'b1;
      tick(); chk("post_rst_wr_en", wr_en, 0);
      tick(); chk("post_rst_wr_en2", wr_en, 0);
      chk("post_rst_busy", busy, 0);
      load_valid = 1'b0; load_last = 1'b0;

      // reset at RUN cycle 10
      start = 1'b1; tick(); start = 1'b0;
      drive_word(0, 1'b0); tick();
      drive_word(1, 1'b0); tick();
      load_valid = 1'b0; load_last = 1'b0;
      repeat (10) tick();
      chk("run10_core_rst_n", core_rst_n, 1);
      rst = 1'b0; #1;
      chk("run_rst_core_rst_n", core_rst_n, 0);
      chk("run_rst_busy", busy, 0);
      @(negedge clk) rst = 1'b1;
      tick(); tick();
      chk("run_rst_idle_busy", busy, 0);
      chk("run_rst_idle_core", core_rst_n, 0);

      for (int k = 0; k < 6; k++) begin
         nw = vecs[k].nwords;
         for (int i = 0; i < nw; i++) begin
            w_sel[i]  = (i == vecs[k].sel3_pos) ? 2'd3 : 2'd0;
            w_addr[i] = ADDR_W'(i);
            w_data[i] = 32'h1000 + 32'(i);
         end
         for (int i = 0; i < 32; i++) rf[i] = $urandom;
         for (int i = 0; i < NC; i++) begin
            tbl_reg[i] = vecs[k].regs[i];
            tbl_exp[i] = vecs[k].exps[i];
            rf[vecs[k].regs[i]] = vecs[k].rdv[i];
         end
         run_seq(vecs[k].halt_at, vecs[k].exp_err, vecs[k].exp_fail,
                 vecs[k].exp_pass, vecs[k].exp_run, 1'b0);
      end

      for (int k = 0; k < 25; k++) begin
         nw = $urandom_range(1, 6);
         for (int i = 0; i < nw; i++) begin
            w_sel[i]  = 2'($urandom_range(0, 3));
            w_addr[i] = ADDR_W'($urandom);
            w_data[i] = $urandom;
         end
         for (int i = 0; i < 32; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         for (int i = 0; i < NC; i++) begin
            tbl_reg[i] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) tbl_reg[i] = 5'd0;
            if ($urandom_range(0, 2) != 0) tbl_exp[i] = (tbl_reg[i] == 5'd0) ? '0 : rf[tbl_reg[i]];
            else                           tbl_exp[i] = 32'($urandom_range(0, 3));
         end
         h = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 45));
         e_err = 0; e_fail = 0;
         for (int i = 0; i < NC; i++) begin
            v = (tbl_reg[i] == 5'd0) ? '0 : rf[tbl_reg[i]];
            if (v != tbl_exp[i]) begin
               if (e_err == 0) e_fail = i;
               if (e_err < 63) e_err++;
            end
         end
         e_run = (h >= 0 && h < RC) ? h + 1 : RC;
         run_seq(h, e_err, e_fail, (e_err == 0), e_run, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
